// File: rtl/register_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : Utilities (package)
//  Purpose  : Shared constants for the register bank: NZCV flag bit indices
//             and the flag vector width.
//  Ports    : n/a
//  Revision : 1.0 - initial release
// ============================================================================
package Utilities;

    localparam int NFLAGS = 4;

    // Bit positions inside the 4-bit NZCV vector.
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage : Utilities
`default_nettype wire

// File: rtl/register_bank_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Purpose  : Per-register "pending load" bits. A claim sets a bit. A port-B
//             (load return) write clears it. A port-A write also clears it.
//             A claim in the same cycle always wins over either clear.
//  Ports    : clock, reset (sync, active-high), hold (freeze)
//             claim_en/claim_sel  - mark register pending
//             clra_en/clra_sel    - clear from write port A
//             clrb_en/clrb_sel    - clear from write port B
//             busy_vec            - registered scoreboard
//             busy_next           - post-update scoreboard (current cycle)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_sel,
    input  logic             clra_en,
    input  logic [AW-1:0]    clra_sel,
    input  logic             clrb_en,
    input  logic [AW-1:0]    clrb_sel,
    output logic [NREGS-1:0] busy_vec,
    output logic [NREGS-1:0] busy_next
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Clears are applied first and the claim last, so a claim of the same
    // register in the same cycle leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (clrb_en) begin
            busy_d[clrb_sel] = 1'b0;
        end
        if (clra_en) begin
            busy_d[clra_sel] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_sel] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q <= '0;
        end else if (!hold) begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec  = busy_q;
    assign busy_next = hold ? busy_q : busy_d;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : register_bank
//  Purpose  : Multi-read, dual-write register file with write-to-read bypass,
//             NZCV flag register and load scoreboard. It has no opcode
//             knowledge; decode gates the enables.
//  Ports    : clock, reset (sync, active-high), hold (freeze everything)
//             rd_sel[NRD] -> rd_data[NRD], rd_busy[NRD]  (1-cycle latency)
//             wa_en/wa_sel/wa_data  - write port A (ALU result, priority)
//             wb_en/wb_sel/wb_data  - write port B (load return)
//             claim_en/claim_sel    - mark register pending a load
//             flags_in/flags_we -> flags (masked NZCV update)
//             busy_vec              - full scoreboard
//  Revision : 1.0 - initial release
// ============================================================================
module register_bank
    import Utilities::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NREGS  = 16,
    parameter  int NRD    = 3,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hold,
    input  logic [AW-1:0]     rd_sel   [NRD],
    output logic [DATA_W-1:0] rd_data  [NRD],
    output logic              rd_busy  [NRD],
    input  logic              wa_en,
    input  logic [AW-1:0]     wa_sel,
    input  logic [DATA_W-1:0] wa_data,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              claim_en,
    input  logic [AW-1:0]     claim_sel,
    input  logic [NFLAGS-1:0] flags_in,
    input  logic [NFLAGS-1:0] flags_we,
    output logic [NFLAGS-1:0] flags,
    output logic [NREGS-1:0]  busy_vec
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] flags_d;
    logic [NREGS-1:0]  busy_next;

    // ------------------------------------------------------------------
    // Register array. Port B is written first and port A last, so on a
    // same-register collision the ALU result is what lands.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (!hold) begin
            if (wb_en) begin
                regs_q[wb_sel] <= wb_data;
            end
            if (wa_en) begin
                regs_q[wa_sel] <= wa_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flags: each NZCV bit takes the new value only when its mask bit is set.
    // ------------------------------------------------------------------
    always_comb begin
        flags_d         = flags_q;
        flags_d[FLAG_N] = flags_we[FLAG_N] ? flags_in[FLAG_N] : flags_q[FLAG_N];
        flags_d[FLAG_Z] = flags_we[FLAG_Z] ? flags_in[FLAG_Z] : flags_q[FLAG_Z];
        flags_d[FLAG_C] = flags_we[FLAG_C] ? flags_in[FLAG_C] : flags_q[FLAG_C];
        flags_d[FLAG_V] = flags_we[FLAG_V] ? flags_in[FLAG_V] : flags_q[FLAG_V];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= '0;
        end else if (!hold) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

    // ------------------------------------------------------------------
    // Scoreboard. Hold gating lives inside the sub-module.
    // ------------------------------------------------------------------
    reg_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .clra_en   (wa_en),
        .clra_sel  (wa_sel),
        .clrb_en   (wb_en),
        .clrb_sel  (wb_sel),
        .busy_vec  (busy_vec),
        .busy_next (busy_next)
    );

    // ------------------------------------------------------------------
    // Read ports. The bypass mux uses the same A-over-B priority as the
    // array write, and rd_busy reads the post-update scoreboard, so a read
    // always sees the state as it will be after this edge.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic              busy_q;

        always_comb begin
            if (wa_en && (wa_sel == rd_sel[p])) begin
                data_d = wa_data;
            end else if (wb_en && (wb_sel == rd_sel[p])) begin
                data_d = wb_data;
            end else begin
                data_d = regs_q[rd_sel[p]];
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                data_q <= '0;
                busy_q <= 1'b0;
            end else if (!hold) begin
                data_q <= data_d;
                busy_q <= busy_next[rd_sel[p]];
            end
        end

        assign rd_data[p] = data_q;
        assign rd_busy[p] = busy_q;
    end

endmodule : register_bank
`default_nettype wire

// File: tb/tb_register_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_bank
//  Purpose  : Self-checking bench for register_bank. A behavioural model
//             predicts every output for each driven cycle and pushes it to
//             a queue; the entry is popped and compared after the edge.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_bank;

    localparam int DW  = 32;
    localparam int NR  = 16;
    localparam int NRD = 3;
    localparam int AW  = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          hold;
    logic [AW-1:0] rd_sel  [NRD];
    logic [DW-1:0] rd_data [NRD];
    logic          rd_busy [NRD];
    logic          wa_en;
    logic [AW-1:0] wa_sel;
    logic [DW-1:0] wa_data;
    logic          wb_en;
    logic [AW-1:0] wb_sel;
    logic [DW-1:0] wb_data;
    logic          claim_en;
    logic [AW-1:0] claim_sel;
    logic [3:0]    flags_in;
    logic [3:0]    flags_we;
    logic [3:0]    flags;
    logic [NR-1:0] busy_vec;

    always #5 clock = ~clock;

    register_bank #(
        .DATA_W (DW),
        .NREGS  (NR),
        .NRD    (NRD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .hold      (hold),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wa_en     (wa_en),
        .wa_sel    (wa_sel),
        .wa_data   (wa_data),
        .wb_en     (wb_en),
        .wb_sel    (wb_sel),
        .wb_data   (wb_data),
        .claim_en  (claim_en),
        .claim_sel (claim_sel),
        .flags_in  (flags_in),
        .flags_we  (flags_we),
        .flags     (flags),
        .busy_vec  (busy_vec)
    );

    typedef struct packed {
        logic [NRD*DW-1:0] rdata;
        logic [NRD-1:0]    rbusy;
        logic [3:0]        flg;
        logic [NR-1:0]     busy;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model state
    logic [DW-1:0] m_regs  [NR];
    logic [NR-1:0] m_busy;
    logic [3:0]    m_flags;
    logic [DW-1:0] e_rdata [NRD];
    logic          e_rbusy [NRD];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        reset    = 1'b0;
        hold     = 1'b0;
        wa_en    = 1'b0;
        wb_en    = 1'b0;
        claim_en = 1'b0;
        flags_we = 4'b0000;
    endtask

    // Predict the outputs for the inputs now on the pins, push them, clock
    // once and compare everything after the edge.
    task automatic cycle();
        exp_t ex;
        exp_t got;
        if (reset) begin
            for (int r = 0; r < NR; r++) m_regs[r] = '0;
            m_busy  = '0;
            m_flags = '0;
            for (int p = 0; p < NRD; p++) begin
                e_rdata[p] = '0;
                e_rbusy[p] = 1'b0;
            end
        end else if (!hold) begin
            if (wb_en) m_regs[wb_sel] = wb_data;
            if (wa_en) m_regs[wa_sel] = wa_data;
            if (wb_en) m_busy[wb_sel] = 1'b0;
            if (wa_en) m_busy[wa_sel] = 1'b0;
            if (claim_en) m_busy[claim_sel] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (flags_we[b]) m_flags[b] = flags_in[b];
            end
            for (int p = 0; p < NRD; p++) begin
                e_rdata[p] = m_regs[rd_sel[p]];
                e_rbusy[p] = m_busy[rd_sel[p]];
            end
        end
        for (int p = 0; p < NRD; p++) begin
            ex.rdata[p*DW +: DW] = e_rdata[p];
            ex.rbusy[p]          = e_rbusy[p];
        end
        ex.flg  = m_flags;
        ex.busy = m_busy;
        exp_q.push_back(ex);

        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        for (int p = 0; p < NRD; p++) begin
            check($sformatf("rd_data[%0d]", p), 64'(rd_data[p]), 64'(got.rdata[p*DW +: DW]));
            check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(got.rbusy[p]));
        end
        check("flags", 64'(flags), 64'(got.flg));
        check("busy_vec", 64'(busy_vec), 64'(got.busy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        m_busy  = '0;
        m_flags = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_sel[p]  = '0;
            e_rdata[p] = '0;
            e_rbusy[p] = 1'b0;
        end
        wa_sel = '0; wa_data = '0; wb_sel = '0; wb_data = '0;
        claim_sel = '0; flags_in = '0;
        idle();

        // Initial reset
        reset = 1'b1;
        cycle();
        check("reset_flags", 64'(flags), 64'h0);
        check("reset_busy", 64'(busy_vec), 64'h0);

        // Write r3, then reset together with hold/write/claim
        idle(); wa_en = 1'b1; wa_sel = 4'd3; wa_data = 32'h11; rd_sel[0] = 4'd3;
        cycle();
        check("r3_written", 64'(rd_data[0]), 64'h11);
        idle(); reset = 1'b1; hold = 1'b1; wa_en = 1'b1; wa_sel = 4'd3; wa_data = 32'h22;
        claim_en = 1'b1; claim_sel = 4'd4; flags_we = 4'hF; flags_in = 4'hF;
        cycle();
        idle();
        cycle();
        check("r3_after_reset", 64'(rd_data[0]), 64'h0);
        check("flags_after_reset", 64'(flags), 64'h0);
        check("busy_after_reset", 64'(busy_vec), 64'h0);

        // Bypass
        idle(); wa_en = 1'b1; wa_sel = 4'd5; wa_data = 32'hDEADBEEF; rd_sel[0] = 4'd5;
        cycle();
        check("bypass_r5", 64'(rd_data[0]), 64'hDEADBEEF);

        // Collision: both ports write r2 while r2 is claimed
        idle(); claim_en = 1'b1; claim_sel = 4'd2;
        cycle();
        check("claim_r2", 64'(busy_vec[2]), 64'h1);
        idle(); wa_en = 1'b1; wa_sel = 4'd2; wa_data = 32'hA;
        wb_en = 1'b1; wb_sel = 4'd2; wb_data = 32'hB; rd_sel[1] = 4'd2;
        cycle();
        check("collision_bypass", 64'(rd_data[1]), 64'hA);
        check("collision_busy", 64'(busy_vec[2]), 64'h0);
        idle(); rd_sel[2] = 4'd2;
        cycle();
        check("collision_stored", 64'(rd_data[2]), 64'hA);

        // Scoreboard: claim wins over same-cycle clear
        idle(); claim_en = 1'b1; claim_sel = 4'd7; rd_sel[0] = 4'd7;
        cycle();
        check("claim_r7_rdbusy", 64'(rd_busy[0]), 64'h1);
        idle(); wb_en = 1'b1; wb_sel = 4'd7; wb_data = 32'h77; claim_en = 1'b1; claim_sel = 4'd7;
        cycle();
        check("claim_clear_same", 64'(busy_vec[7]), 64'h1);
        idle(); wb_en = 1'b1; wb_sel = 4'd7; wb_data = 32'h78;
        cycle();
        check("wb_clear_r7", 64'(busy_vec[7]), 64'h0);
        check("wb_clear_rdbusy", 64'(rd_busy[0]), 64'h0);
        check("wb_data_r7", 64'(rd_data[0]), 64'h78);

        // Masked flag update
        idle(); flags_in = 4'b1111; flags_we = 4'b0101;
        cycle();
        check("flags_masked", 64'(flags), 64'h5);

        // Hold freezes everything
        idle(); rd_sel[0] = 4'd5;
        cycle();
        check("pre_hold_read", 64'(rd_data[0]), 64'hDEADBEEF);
        idle(); hold = 1'b1; wa_en = 1'b1; wa_sel = 4'd1; wa_data = 32'h5;
        claim_en = 1'b1; claim_sel = 4'd1; flags_in = 4'b1010; flags_we = 4'hF; rd_sel[0] = 4'd1;
        cycle();
        check("hold_rd_frozen", 64'(rd_data[0]), 64'hDEADBEEF);
        check("hold_busy1", 64'(busy_vec[1]), 64'h0);
        check("hold_flags", 64'(flags), 64'h5);
        idle();
        cycle();
        check("after_hold_r1", 64'(rd_data[0]), 64'h0);
        check("after_hold_busy1", 64'(busy_vec[1]), 64'h0);

        // Random traffic against the model
        for (int n = 0; n < 60; n++) begin
            idle();
            hold      = ($urandom_range(0, 5) == 0);
            wa_en     = 1'($urandom_range(0, 1));
            wa_sel    = 4'($urandom_range(0, 7));
            wa_data   = $urandom;
            wb_en     = 1'($urandom_range(0, 1));
            wb_sel    = 4'($urandom_range(0, 7));
            wb_data   = $urandom;
            claim_en  = 1'($urandom_range(0, 1));
            claim_sel = 4'($urandom_range(0, 7));
            flags_in  = 4'($urandom);
            flags_we  = 4'($urandom);
            for (int p = 0; p < NRD; p++) rd_sel[p] = 4'($urandom_range(0, 15));
            cycle();
        end

        // Reset beats hold and claims
        idle(); reset = 1'b1; hold = 1'b1; claim_en = 1'b1; claim_sel = 4'd9;
        cycle();
        check("final_reset_busy", 64'(busy_vec), 64'h0);
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_register_bank
`default_nettype wire
